// File: rtl/sdr_data_path.sv
// SDRAM data path: serialises system write words into DQ beats with per-beat DQM and
// assembles CAS-delayed read beats into system words, flagging ignored start strobes.
module sdr_data_path #(
    parameter int SYS_W   = 32,
    parameter int DQ_W    = 8,
    parameter int CAS_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_start,
    input  logic [SYS_W-1:0]        wr_data,
    input  logic [SYS_W/DQ_W-1:0]   wr_beat_mask,
    output logic                    wr_done,
    input  logic                    rd_start,
    output logic [SYS_W-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    proto_err,
    output logic [DQ_W-1:0]         sdr_dq_out,
    output logic                    sdr_dq_oe,
    output logic                    sdr_dqm,
    input  logic [DQ_W-1:0]         sdr_dq_in
);
    // state   | meaning
    // IDLE    | no burst, starts accepted
    // WRITE   | driving write beats onto DQ
    // RD_WAIT | waiting out CAS latency after READ
    // READ    | sampling read beats from DQ
    localparam int BEATS = SYS_W / DQ_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [1:0] WAIT_INIT = (CAS_LAT > 1) ? 2'(CAS_LAT - 2) : 2'd0;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] READ    = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       wait_cnt;
    logic [SYS_W-1:0] wr_shift;
    logic [SYS_W-1:0] rd_shift;
    logic [BEATS-1:0] mask_shift;
    logic             idle;

    assign idle = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            wr_shift   <= '0;
            rd_shift   <= '0;
            mask_shift <= '0;
            wr_done    <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
            sdr_dq_out <= '0;
            sdr_dq_oe  <= 1'b0;
            sdr_dqm    <= 1'b1;
        end else begin
            wr_done   <= 1'b0;
            rd_valid  <= 1'b0;
            // A simultaneous pair loses the read; anything while busy is dropped.
            proto_err <= (wr_start && rd_start) || (!idle && (wr_start || rd_start));
            case (state)
                IDLE: begin
                    if (wr_start) begin
                        state      <= WRITE;
                        beat_cnt   <= LAST_BEAT;
                        busy       <= 1'b1;
                        sdr_dq_oe  <= 1'b1;
                        sdr_dq_out <= wr_data[DQ_W-1:0];
                        sdr_dqm    <= wr_beat_mask[0];
                        wr_shift   <= wr_data >> DQ_W;
                        mask_shift <= wr_beat_mask >> 1;
                    end else if (rd_start) begin
                        state    <= (CAS_LAT == 1) ? READ : RD_WAIT;
                        beat_cnt <= LAST_BEAT;
                        wait_cnt <= WAIT_INIT;
                        busy     <= 1'b1;
                        sdr_dqm  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (beat_cnt == '0) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        wr_done    <= 1'b1;
                        sdr_dq_oe  <= 1'b0;
                        sdr_dqm    <= 1'b1;
                        sdr_dq_out <= '0;
                    end else begin
                        sdr_dq_out <= wr_shift[DQ_W-1:0];
                        sdr_dqm    <= mask_shift[0];
                        wr_shift   <= wr_shift >> DQ_W;
                        mask_shift <= mask_shift >> 1;
                        beat_cnt   <= beat_cnt - 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= READ;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                READ: begin
                    // Beats enter at the top so beat 0 ends up in the LSBs.
                    rd_shift <= {sdr_dq_in, rd_shift[SYS_W-1:DQ_W]};
                    if (beat_cnt == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rd_valid <= 1'b1;
                        rd_data  <= {sdr_dq_in, rd_shift[SYS_W-1:DQ_W]};
                        sdr_dqm  <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
